// File: rtl/shift_reg_pkg.sv
// Shared types for the parallel-in serial-out stage: frame FSM states and counter sizing.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg_ctrl_if.sv
// Load handshake plus serial framing outputs of the PISO stage.
interface piso_shift_reg_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit index of the data bit currently on sout; clears on load, saturates at WIDTH-1.
module piso_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last,
  output logic penult
);
  localparam int              CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PEN_IDX  = CNT_W'(WIDTH - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last   = (cnt == LAST_IDX);
  assign penult = (cnt == PEN_IDX);
endmodule

// File: rtl/piso_shift_reg_ctrl.sv
// Serialises a WIDTH-bit word, one bit per clock, starting the cycle after the load is accepted.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_shift_reg_ctrl_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             par;
  logic             sout_q;
  logic             sout_valid_q;
  logic             done_q;
  logic             last;
  logic             penult;
  logic             ready_c;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // The cycle that carries the final frame bit can take the next word, so frames abut.
  assign ready_c = (state == IDLE) ||
                   (PAR_EN ? (state == PARITY) : (state == SHIFT && last));
  assign accept  = bus.load_valid && ready_c && !rst;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    (state == SHIFT),
    .last   (last),
    .penult (penult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sreg         <= '0;
      par          <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (accept) begin
      state        <= SHIFT;
      sout_q       <= head(bus.din);
      sreg         <= adv(bus.din);
      par          <= ^bus.din;
      sout_valid_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (!last) begin
            sout_q <= head(sreg);
            sreg   <= adv(sreg);
            done_q <= penult && !PAR_EN;
          end else if (PAR_EN) begin
            state  <= PARITY;
            sout_q <= par;
            done_q <= 1'b1;
          end else begin
            state        <= IDLE;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = ready_c;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_shift_reg_ctrl.sv
// Directed bench for piso_shift_reg_ctrl: MSB-first and LSB-first instances, WIDTH=4.
module tb_piso_shift_reg_ctrl;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       lsb;   // 1: drive the LSB-first instance
    logic [3:0] din;
    logic [3:0] seq;   // expected bits in emit order, seq[3] first
    logic       par;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[6];

  piso_shift_reg_ctrl_if #(.WIDTH(4)) bm ();
  piso_shift_reg_ctrl_if #(.WIDTH(4)) bl ();

  piso_shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  piso_shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic drive(input logic lsb, input logic [3:0] d, input logic v);
    if (lsb) begin
      bl.din = d;
      bl.load_valid = v;
    end else begin
      bm.din = d;
      bm.load_valid = v;
    end
  endtask

  // {load_ready, sout, sout_valid, busy, done}
  function automatic logic [4:0] outs(input logic lsb);
    if (lsb) return {bl.load_ready, bl.sout, bl.sout_valid, bl.busy, bl.done};
    return {bm.load_ready, bm.sout, bm.sout_valid, bm.busy, bm.done};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual rdy/sout/vld/busy/done=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic expect_cycle(input logic lsb, input string nm, input logic s,
                              input logic d, input logic r);
    @(negedge clk);
    chk(nm, outs(lsb), {r, s, 1'b1, 1'b1, d});
  endtask

  task automatic expect_idle(input logic lsb, input string nm);
    @(negedge clk);
    chk(nm, outs(lsb), 5'b10000);
  endtask

  task automatic accept(input logic lsb, input logic [3:0] d);
    @(posedge clk);
    #1 drive(lsb, d, 1'b1);
    @(posedge clk);
    #1 drive(lsb, d, 1'b0);
  endtask

  task automatic frame_bits(input logic lsb, input logic [3:0] seq, input logic par,
                            input string nm);
    for (int k = 0; k < 4; k++) begin
      expect_cycle(lsb, $sformatf("%s b%0d", nm, k), seq[3-k],
                   (k == 3) && !PAR_EN, (k == 3) && !PAR_EN);
    end
    if (PAR_EN) expect_cycle(lsb, $sformatf("%s par", nm), par, 1'b1, 1'b1);
  endtask

  task automatic run_frame(input logic lsb, input logic [3:0] seq, input logic par,
                           input string nm);
    frame_bits(lsb, seq, par, nm);
    expect_idle(lsb, $sformatf("%s idle", nm));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{"m1011", 1'b0, 4'b1011, 4'b1011, 1'b1};
    vecs[1] = '{"l0011", 1'b1, 4'b0011, 4'b1100, 1'b0};
    vecs[2] = '{"m1001", 1'b0, 4'b1001, 4'b1001, 1'b0};
    vecs[3] = '{"l1000", 1'b1, 4'b1000, 4'b0001, 1'b1};
    vecs[4] = '{"m0110", 1'b0, 4'b0110, 4'b0110, 1'b0};
    vecs[5] = '{"l1101", 1'b1, 4'b1101, 4'b1011, 1'b1};

    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset msb", outs(1'b0), 5'b10000);
    chk("reset lsb", outs(1'b1), 5'b10000);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].lsb, vecs[i].din);
      run_frame(vecs[i].lsb, vecs[i].seq, vecs[i].par, vecs[i].name);
    end

    // Word held on load_valid through the busy cycles, taken only on the final frame bit.
    accept(1'b0, 4'b1000);
    drive(1'b0, 4'b0001, 1'b1);
    frame_bits(1'b0, 4'b1000, 1'b1, "b2b first");
    @(posedge clk);
    #1 drive(1'b0, 4'b0001, 1'b0);
    run_frame(1'b0, 4'b0001, 1'b1, "b2b second");

    // Reset mid-frame aborts with no done; a load pending during reset is ignored.
    accept(1'b0, 4'b1011);
    expect_cycle(1'b0, "abort b0", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 4'b0110, 1'b1);
    expect_cycle(1'b0, "abort b1", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort state", outs(1'b0), 5'b10000);
    @(posedge clk);
    #1 drive(1'b0, 4'b0110, 1'b0);
    run_frame(1'b0, 4'b0110, 1'b0, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
